// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_arbiter
// Description : Two-port round-robin arbiter and timing sequencer for an
//               external asynchronous SRAM (byte wide, low lane only).
//               Port A is the CPU/chipset requester and port B is the
//               video/DMA requester. One access is in flight at a time.
//               This block drives the address, the write-data tristate
//               (data + enable) and WE_n. CE_n, OE_n and LB_n are tied off
//               at the top level.
// Ports       : clk_100, reset_n          clock / async active-low reset
//               {a,b}_req/_we/_addr/_wdata requester inputs (level request)
//               {a,b}_rdata, {a,b}_ack     read data and 1-cycle completion
//               sram_addr_o, sram_data_o   SRAM address and write data
//               sram_data_i                SRAM read data from the pins
//               sram_data_oe, sram_we_n_o  data tristate enable, write strobe
//               busy, owner_b              not-IDLE flag, last granted port
// Revision    : 1.0 - initial release
// ============================================================================
module sram_arbiter #(
    parameter int ADDR_W     = 21,
    parameter int DATA_W     = 8,
    parameter int ACCESS_CYC = 2
) (
    input  logic              clk_100,
    input  logic              reset_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_ack,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_ack,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [DATA_W-1:0] sram_data_o,
    input  logic [DATA_W-1:0] sram_data_i,
    output logic              sram_data_oe,
    output logic              sram_we_n_o,
    output logic              busy,
    output logic              owner_b
);

    localparam int                CNT_W      = $clog2(ACCESS_CYC + 1);
    localparam logic [CNT_W-1:0]  c_CNT_LOAD = CNT_W'(ACCESS_CYC - 1);

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_RD       = 3'd1;
    localparam logic [2:0] c_ST_WR_SETUP = 3'd2;
    localparam logic [2:0] c_ST_WR_PULSE = 3'd3;
    localparam logic [2:0] c_ST_WR_HOLD  = 3'd4;
    localparam logic [2:0] c_ST_DONE     = 3'd5;

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_owner_b;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_a_rdata;
    logic [DATA_W-1:0] r_b_rdata;
    logic              r_a_ack;
    logic              r_b_ack;
    logic              r_busy;
    logic              r_oe;
    logic              r_we_n;

    logic              w_any_req;
    logic              w_grant_b;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_cnt_zero;
    logic              w_we_n_nxt;
    logic              w_oe_nxt;
    logic              w_busy_nxt;
    logic              w_a_ack_nxt;
    logic              w_b_ack_nxt;

    // Round robin: on a tie the port that did NOT own the last grant wins.
    // owner_b resets to 1 so port A wins the very first tie.
    assign w_any_req   = a_req | b_req;
    assign w_grant_b   = b_req & (~a_req | ~r_owner_b);
    assign w_sel_we    = w_grant_b ? b_we    : a_we;
    assign w_sel_addr  = w_grant_b ? b_addr  : a_addr;
    assign w_sel_wdata = w_grant_b ? b_wdata : a_wdata;
    assign w_cnt_zero  = (r_cnt == '0);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = w_sel_we ? c_ST_WR_SETUP : c_ST_RD;
                end
            end
            c_ST_RD: begin
                if (w_cnt_zero) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_WR_SETUP: w_state_nxt = c_ST_WR_PULSE;
            c_ST_WR_PULSE: begin
                if (w_cnt_zero) begin
                    w_state_nxt = c_ST_WR_HOLD;
                end
            end
            c_ST_WR_HOLD:  w_state_nxt = c_ST_DONE;
            c_ST_DONE:     w_state_nxt = c_ST_IDLE;
            default:       w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode from the next state; registered below so every pin is
    // a flop output and lines up with the state it belongs to.
    // ------------------------------------------------------------------
    always_comb begin
        w_we_n_nxt  = (w_state_nxt != c_ST_WR_PULSE);
        w_oe_nxt    = (w_state_nxt == c_ST_WR_SETUP) ||
                      (w_state_nxt == c_ST_WR_PULSE) ||
                      (w_state_nxt == c_ST_WR_HOLD);
        w_busy_nxt  = (w_state_nxt != c_ST_IDLE);
        // No grant can happen on the way into DONE, so r_owner_b is current.
        w_a_ack_nxt = (w_state_nxt == c_ST_DONE) && !r_owner_b;
        w_b_ack_nxt = (w_state_nxt == c_ST_DONE) &&  r_owner_b;
    end

    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            r_we_n  <= 1'b1;
            r_oe    <= 1'b0;
            r_busy  <= 1'b0;
            r_a_ack <= 1'b0;
            r_b_ack <= 1'b0;
        end else begin
            r_we_n  <= w_we_n_nxt;
            r_oe    <= w_oe_nxt;
            r_busy  <= w_busy_nxt;
            r_a_ack <= w_a_ack_nxt;
            r_b_ack <= w_b_ack_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Datapath: grant latch, access timer, read capture.
    // The address/data registers only load at a grant, so they are stable
    // for the whole access (in particular while WE_n is low) and keep
    // their last value through DONE and IDLE.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_owner_b <= 1'b1;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_a_rdata <= '0;
            r_b_rdata <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_any_req) begin
                        r_cnt     <= c_CNT_LOAD;
                        r_owner_b <= w_grant_b;
                        r_addr    <= w_sel_addr;
                        if (w_sel_we) begin
                            r_wdata <= w_sel_wdata;
                        end
                    end
                end
                c_ST_RD: begin
                    if (w_cnt_zero) begin
                        if (r_owner_b) begin
                            r_b_rdata <= sram_data_i;
                        end else begin
                            r_a_rdata <= sram_data_i;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                // WR_SETUP leaves the count untouched so WR_PULSE gets the
                // full ACCESS_CYC cycles.
                c_ST_WR_PULSE: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign a_rdata      = r_a_rdata;
    assign b_rdata      = r_b_rdata;
    assign a_ack        = r_a_ack;
    assign b_ack        = r_b_ack;
    assign sram_addr_o  = r_addr;
    assign sram_data_o  = r_wdata;
    assign sram_data_oe = r_oe;
    assign sram_we_n_o  = r_we_n;
    assign busy         = r_busy;
    assign owner_b      = r_owner_b;

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_arbiter
// Description : Self-checking bench for sram_arbiter. Two instances: one
//               with ACCESS_CYC=2 (main) and one with ACCESS_CYC=1. A
//               behavioural SRAM array sits on the pins; a transaction-level
//               reference memory and fairness bookkeeping check random
//               traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;

    localparam int AC0 = 2;
    localparam int AC1 = 1;

    logic clk_100 = 1'b0;
    logic reset_n;
    always #5 clk_100 = ~clk_100;

    // instance 0 (ACCESS_CYC = 2)
    logic        a_req, a_we, a_ack, b_req, b_we, b_ack;
    logic [20:0] a_addr, b_addr, sram_addr_o;
    logic [7:0]  a_wdata, a_rdata, b_wdata, b_rdata, sram_data_o, sram_data_i;
    logic        sram_data_oe, sram_we_n_o, busy, owner_b;
    // instance 1 (ACCESS_CYC = 1)
    logic        a_req_1, a_we_1, a_ack_1, b_req_1, b_we_1, b_ack_1;
    logic [20:0] a_addr_1, b_addr_1, sram_addr_1;
    logic [7:0]  a_wdata_1, a_rdata_1, b_wdata_1, b_rdata_1, sram_dout_1, sram_din_1;
    logic        sram_oe_1, sram_we_n_1, busy_1, owner_b_1;

    sram_arbiter #(.ADDR_W(21), .DATA_W(8), .ACCESS_CYC(AC0)) u_dut0 (
        .clk_100(clk_100), .reset_n(reset_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(a_rdata), .a_ack(a_ack),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(b_rdata), .b_ack(b_ack),
        .sram_addr_o(sram_addr_o), .sram_data_o(sram_data_o), .sram_data_i(sram_data_i),
        .sram_data_oe(sram_data_oe), .sram_we_n_o(sram_we_n_o),
        .busy(busy), .owner_b(owner_b)
    );

    sram_arbiter #(.ADDR_W(21), .DATA_W(8), .ACCESS_CYC(AC1)) u_dut1 (
        .clk_100(clk_100), .reset_n(reset_n),
        .a_req(a_req_1), .a_we(a_we_1), .a_addr(a_addr_1), .a_wdata(a_wdata_1),
        .a_rdata(a_rdata_1), .a_ack(a_ack_1),
        .b_req(b_req_1), .b_we(b_we_1), .b_addr(b_addr_1), .b_wdata(b_wdata_1),
        .b_rdata(b_rdata_1), .b_ack(b_ack_1),
        .sram_addr_o(sram_addr_1), .sram_data_o(sram_dout_1), .sram_data_i(sram_din_1),
        .sram_data_oe(sram_oe_1), .sram_we_n_o(sram_we_n_1),
        .busy(busy_1), .owner_b(owner_b_1)
    );

    // Behavioural asynchronous SRAM shared by both instances (they are never
    // active at the same time). Read data is refreshed on the falling edge.
    logic [7:0]  mem [0:(1<<21)-1];
    logic        bd_we = 1'b0;
    logic [20:0] bd_addr = '0;
    logic [7:0]  bd_data = '0;

    always @(posedge clk_100) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        if (!sram_we_n_o && sram_data_oe) mem[sram_addr_o] <= sram_data_o;
        if (!sram_we_n_1 && sram_oe_1) mem[sram_addr_1] <= sram_dout_1;
    end

    always @(negedge clk_100) begin
        sram_data_i <= mem[sram_addr_o];
        sram_din_1  <= mem[sram_addr_1];
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic backdoor(input logic [20:0] addr, input logic [7:0] data);
        bd_addr = addr;
        bd_data = data;
        bd_we   = 1'b1;
        @(negedge clk_100);
        bd_we   = 1'b0;
    endtask

    task automatic set_port(input bit d1, input bit pb, input bit req, input bit we,
                            input logic [20:0] addr, input logic [7:0] wd);
        if (!d1 && !pb) begin a_req = req; a_we = we; a_addr = addr; a_wdata = wd; end
        if (!d1 &&  pb) begin b_req = req; b_we = we; b_addr = addr; b_wdata = wd; end
        if ( d1 && !pb) begin a_req_1 = req; a_we_1 = we; a_addr_1 = addr; a_wdata_1 = wd; end
        if ( d1 &&  pb) begin b_req_1 = req; b_we_1 = we; b_addr_1 = addr; b_wdata_1 = wd; end
    endtask

    task automatic apply_reset();
        @(negedge clk_100);
        reset_n = 1'b0;
        for (int p = 0; p < 2; p++) begin
            set_port(1'b0, p[0], 1'b0, 1'b0, '0, '0);
            set_port(1'b1, p[0], 1'b0, 1'b0, '0, '0);
        end
        repeat (2) @(negedge clk_100);
        reset_n = 1'b1;
    endtask

    // Single isolated transaction. Cycle n is observed on the falling edge
    // after rising edge n-1, where edge 0 is the one that samples req.
    int          x_ack_cyc, x_we_low, x_first_low, x_oe_cnt, x_both;
    logic [7:0]  x_rdata;
    logic        s_we   [16];
    logic        s_oe   [16];
    logic [20:0] s_addr [16];

    task automatic do_xact(input bit d1, input bit pb, input bit we,
                           input logic [20:0] addr, input logic [7:0] wd);
        logic ak;
        @(negedge clk_100);
        x_ack_cyc = 0; x_we_low = 0; x_first_low = 0; x_oe_cnt = 0; x_both = 0; x_rdata = '0;
        for (int i = 0; i < 16; i++) begin s_we[i] = 1'b1; s_oe[i] = 1'b0; s_addr[i] = '0; end
        set_port(d1, pb, 1'b1, we, addr, wd);
        for (int n = 1; n < 16; n++) begin
            @(negedge clk_100);
            s_we[n]   = d1 ? sram_we_n_1 : sram_we_n_o;
            s_oe[n]   = d1 ? sram_oe_1   : sram_data_oe;
            s_addr[n] = d1 ? sram_addr_1 : sram_addr_o;
            if (!s_we[n]) begin
                x_we_low++;
                if (x_first_low == 0) x_first_low = n;
            end
            if (s_oe[n]) x_oe_cnt++;
            if (d1 ? (a_ack_1 && b_ack_1) : (a_ack && b_ack)) x_both++;
            ak = d1 ? (pb ? b_ack_1 : a_ack_1) : (pb ? b_ack : a_ack);
            if (ak) begin
                x_ack_cyc = n;
                x_rdata   = d1 ? (pb ? b_rdata_1 : a_rdata_1) : (pb ? b_rdata : a_rdata);
                break;
            end
        end
        set_port(d1, pb, 1'b0, we, addr, wd);
    endtask

    // Random-traffic reference: transaction-level memory plus fairness
    // bookkeeping (foreign completions seen while a request is pending).
    logic [7:0]  ref_mem [logic [20:0]];
    bit          pend    [2];
    bit          p_we    [2];
    logic [20:0] p_addr  [2];
    logic [7:0]  p_wd    [2];
    int          wt      [2];
    int          foreign [2];
    int          n_done = 0;

    function automatic logic [7:0] ref_get(input logic [20:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    task automatic rnd_observe();
        bit ak [2];
        ak[0] = a_ack;
        ak[1] = b_ack;
        if (a_ack || b_ack) chk("rnd_single_ack", {31'd0, a_ack & b_ack}, 32'd0);
        if (!sram_we_n_o)   chk("rnd_we_needs_oe", {31'd0, sram_data_oe}, 32'd1);
        for (int p = 0; p < 2; p++) begin
            if (ak[p]) begin
                chk("rnd_ack_pending", {31'd0, pend[p]}, 32'd1);
                chk("rnd_owner_at_ack", {31'd0, owner_b}, p);
                if (pend[p]) begin
                    if (p_we[p]) ref_mem[p_addr[p]] = p_wd[p];
                    else chk("rnd_rdata", {24'd0, (p == 1) ? b_rdata : a_rdata}, {24'd0, ref_get(p_addr[p])});
                    chk("rnd_fair_wait", foreign[p], (foreign[p] <= 1) ? foreign[p] : 1);
                    if (pend[1-p]) foreign[1-p]++;
                    pend[p] = 1'b0;
                    n_done++;
                end
            end
        end
        for (int p = 0; p < 2; p++) begin
            if (pend[p]) begin
                wt[p]++;
                if (wt[p] > 40) begin
                    chk("rnd_timeout", wt[p], 32'd40);
                    pend[p] = 1'b0;
                end
            end
        end
    endtask

    task automatic rnd_drive(input bit allow_new);
        for (int p = 0; p < 2; p++) begin
            if (!pend[p]) begin
                if (allow_new && $urandom_range(0, 2) != 0) begin
                    pend[p]    = 1'b1;
                    p_we[p]    = $urandom_range(0, 1) == 1;
                    p_addr[p]  = 21'h100000 | 21'($urandom_range(0, 15));
                    p_wd[p]    = 8'($urandom);
                    wt[p]      = 0;
                    foreign[p] = 0;
                    set_port(1'b0, p[0], 1'b1, p_we[p], p_addr[p], p_wd[p]);
                end else begin
                    set_port(1'b0, p[0], 1'b0, 1'b0, '0, '0);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int   first, a_hi, b_hi, both, k, na, nb, acks;
        bit   got_a, got_b, gap_pend, found, stable;
        logic seq [6];

        reset_n = 1'b0;
        for (int p = 0; p < 2; p++) begin
            set_port(1'b0, p[0], 1'b0, 1'b0, '0, '0);
            set_port(1'b1, p[0], 1'b0, 1'b0, '0, '0);
        end
        backdoor(21'h1ABCD, 8'h5A);
        for (int i = 0; i < 16; i++) backdoor(21'h100000 + 21'(i), 8'h00);

        // ---------------- reset state ----------------
        chk("rst_we_oe_busy_owner", {28'd0, sram_we_n_o, sram_data_oe, busy, owner_b}, 32'h9);
        chk("rst_addr", {11'd0, sram_addr_o}, 32'd0);
        chk("rst_wdata_rdata", {8'd0, sram_data_o, a_rdata, b_rdata}, 32'd0);
        chk("rst_acks", {30'd0, a_ack, b_ack}, 32'd0);
        chk("rst1_we_oe_busy_owner", {28'd0, sram_we_n_1, sram_oe_1, busy_1, owner_b_1}, 32'h9);
        @(negedge clk_100);
        reset_n = 1'b1;

        // ---------------- A read, ACCESS_CYC=2 ----------------
        do_xact(1'b0, 1'b0, 1'b0, 21'h1ABCD, 8'h00);
        chk("rd_ack_cycle", x_ack_cyc, AC0 + 1);
        chk("rd_rdata", {24'd0, x_rdata}, 32'h5A);
        chk("rd_we_never_low", x_we_low, 0);
        chk("rd_oe_never_high", x_oe_cnt, 0);

        // ---------------- B write, ACCESS_CYC=2 ----------------
        do_xact(1'b0, 1'b1, 1'b1, 21'h000FF, 8'hC3);
        chk("wr_ack_cycle", x_ack_cyc, AC0 + 3);
        chk("wr_we_low_len", x_we_low, AC0);
        chk("wr_we_low_start", x_first_low, 2);
        chk("wr_setup", {10'd0, s_oe[1], s_we[1], s_addr[1]}, {10'd0, 1'b1, 1'b1, 21'h000FF});
        chk("wr_hold", {10'd0, s_oe[AC0+2], s_we[AC0+2], s_addr[AC0+2]}, {10'd0, 1'b1, 1'b1, 21'h000FF});
        stable = 1'b1;
        for (int n = 1; n <= AC0 + 2; n++) if (s_addr[n] !== 21'h000FF) stable = 1'b0;
        chk("wr_addr_stable", {31'd0, stable}, 32'd1);
        @(negedge clk_100);
        chk("wr_mem", {24'd0, mem[21'h000FF]}, 32'hC3);
        chk("rd_a_rdata_held", {24'd0, a_rdata}, 32'h5A);
        chk("wr_addr_kept_idle", {11'd0, sram_addr_o}, 32'h000FF);

        // ---------------- ACCESS_CYC=1 instance ----------------
        do_xact(1'b1, 1'b1, 1'b1, 21'h00200, 8'h44);
        chk("c1_wr_ack_cycle", x_ack_cyc, AC1 + 3);
        chk("c1_wr_we_low_len", x_we_low, AC1);
        chk("c1_wr_hold", {30'd0, s_oe[AC1+2], s_we[AC1+2]}, 32'h3);
        do_xact(1'b1, 1'b0, 1'b0, 21'h00200, 8'h00);
        chk("c1_rd_ack_cycle", x_ack_cyc, AC1 + 1);
        chk("c1_rd_a_rdata", {24'd0, x_rdata}, 32'h44);
        do_xact(1'b1, 1'b1, 1'b0, 21'h00200, 8'h00);
        chk("c1_rd_b_rdata", {24'd0, x_rdata}, 32'h44);

        // ---------------- simultaneous first request ----------------
        apply_reset();
        set_port(1'b0, 1'b0, 1'b1, 1'b0, 21'h00030, 8'h00);
        set_port(1'b0, 1'b1, 1'b1, 1'b0, 21'h00031, 8'h00);
        first = -1; a_hi = 0; b_hi = 0; both = 0; got_a = 1'b0; got_b = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk_100);
            if (a_ack && b_ack) both++;
            if (a_ack) begin
                a_hi++;
                if (first < 0) first = 0;
                got_a = 1'b1;
                set_port(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
            end
            if (b_ack) begin
                b_hi++;
                if (first < 0) first = 1;
                got_b = 1'b1;
                set_port(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
            end
        end
        chk("sim_first_port", first, 0);
        chk("sim_both_served", {30'd0, got_a, got_b}, 32'h3);
        chk("sim_ack_widths", {a_hi[15:0], b_hi[15:0]}, {16'd1, 16'd1});
        chk("sim_never_both", both, 0);

        // ---------------- saturation ----------------
        set_port(1'b0, 1'b0, 1'b1, 1'b0, 21'h00040, 8'h00);
        set_port(1'b0, 1'b1, 1'b1, 1'b0, 21'h00041, 8'h00);
        k = 0; na = 0; nb = 0; gap_pend = 1'b0;
        for (int n = 0; n < 80 && k < 6; n++) begin
            @(negedge clk_100);
            if (gap_pend) begin
                chk("sat_idle_gap", {31'd0, busy}, 32'd0);
                gap_pend = 1'b0;
            end
            if (a_ack || b_ack) begin
                chk("sat_single_ack", {31'd0, a_ack & b_ack}, 32'd0);
                seq[k] = owner_b;
                k++;
                gap_pend = 1'b1;
                if (a_ack) begin na++; if (na == 3) set_port(1'b0, 1'b0, 1'b0, 1'b0, '0, '0); end
                if (b_ack) begin nb++; if (nb == 3) set_port(1'b0, 1'b1, 1'b0, 1'b0, '0, '0); end
            end
        end
        chk("sat_grant_count", k, 6);
        for (int i = 0; i < k; i++) chk("sat_owner_seq", {31'd0, seq[i]}, i % 2);

        // ---------------- reset mid-write ----------------
        apply_reset();
        @(negedge clk_100);
        set_port(1'b0, 1'b0, 1'b1, 1'b1, 21'h00123, 8'h77);
        found = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk_100);
            if (!sram_we_n_o) begin found = 1'b1; break; end
        end
        chk("mw_reached_pulse", {31'd0, found}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mw_async_we_n", {31'd0, sram_we_n_o}, 32'd1);
        chk("mw_async_oe", {31'd0, sram_data_oe}, 32'd0);
        set_port(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        acks = 0;
        repeat (3) begin @(negedge clk_100); if (a_ack || b_ack) acks++; end
        reset_n = 1'b1;
        repeat (3) begin @(negedge clk_100); if (a_ack || b_ack) acks++; end
        chk("mw_no_ack", acks, 0);
        chk("mw_busy_after", {31'd0, busy}, 32'd0);
        do_xact(1'b0, 1'b0, 1'b1, 21'h00124, 8'h99);
        chk("mw_next_wr_ack", x_ack_cyc, AC0 + 3);
        @(negedge clk_100);
        chk("mw_next_wr_mem", {24'd0, mem[21'h00124]}, 32'h99);

        // ---------------- random traffic ----------------
        for (int p = 0; p < 2; p++) begin pend[p] = 1'b0; wt[p] = 0; foreign[p] = 0; end
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk_100);
            rnd_observe();
            rnd_drive(1'b1);
        end
        for (int c = 0; c < 200; c++) begin
            @(negedge clk_100);
            rnd_observe();
            rnd_drive(1'b0);
            if (!pend[0] && !pend[1]) break;
        end
        chk("rnd_drained", {30'd0, pend[0], pend[1]}, 32'd0);
        chk("rnd_progress", {31'd0, n_done >= 100}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
